// File: rtl/ins_encoder_pkg.sv
// MIPS32 definitions shared by the instruction encoder: opcode/func constants,
// the symbolic instruction enum, the encoder FSM states and word-packing helpers.
package ins_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FUNC_SLL  = 6'h00, FUNC_SRL  = 6'h02, FUNC_SRA  = 6'h03, FUNC_SLLV = 6'h04;
    localparam logic [5:0] FUNC_SRLV = 6'h06, FUNC_SRAV = 6'h07, FUNC_JR   = 6'h08, FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21, FUNC_SUB  = 6'h22, FUNC_SUBU = 6'h23, FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25, FUNC_XOR  = 6'h26, FUNC_NOR  = 6'h27, FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        INS_ADD, INS_ADDU, INS_SUB, INS_SUBU, INS_AND, INS_OR, INS_XOR, INS_NOR,
        INS_SLT, INS_SLTU, INS_SLL, INS_SRL, INS_SRA, INS_SLLV, INS_SRLV, INS_SRAV,
        INS_JR, INS_ADDI, INS_ADDIU, INS_ANDI, INS_ORI, INS_XORI, INS_SLTI, INS_LUI,
        INS_LW, INS_SW, INS_BEQ, INS_BNE, INS_J, INS_JAL
    } ins_op_t;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE, ST_ERR} enc_state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, shamt, input logic [5:0] func);
        return {OP_RTYPE, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Control transfers whose delay slot the encoder can fill with a NOP.
    function automatic logic needs_pad(input ins_op_t op);
        return op inside {INS_J, INS_JAL, INS_BEQ, INS_BNE, INS_JR};
    endfunction

endpackage

// File: rtl/ins_encoder_pack.sv
// Combinational packer: symbolic op plus fields -> MIPS32 word; flags ops outside ins_op_t.
module ins_pack
    import ins_encoder_pkg::*;
(
    input  ins_op_t     op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            INS_ADD:   word = r_word(rs, rt, rd, shamt, FUNC_ADD);
            INS_ADDU:  word = r_word(rs, rt, rd, shamt, FUNC_ADDU);
            INS_SUB:   word = r_word(rs, rt, rd, shamt, FUNC_SUB);
            INS_SUBU:  word = r_word(rs, rt, rd, shamt, FUNC_SUBU);
            INS_AND:   word = r_word(rs, rt, rd, shamt, FUNC_AND);
            INS_OR:    word = r_word(rs, rt, rd, shamt, FUNC_OR);
            INS_XOR:   word = r_word(rs, rt, rd, shamt, FUNC_XOR);
            INS_NOR:   word = r_word(rs, rt, rd, shamt, FUNC_NOR);
            INS_SLT:   word = r_word(rs, rt, rd, shamt, FUNC_SLT);
            INS_SLTU:  word = r_word(rs, rt, rd, shamt, FUNC_SLTU);
            // Immediate shifts have no rs; variable shifts have no shamt.
            INS_SLL:   word = r_word(5'd0, rt, rd, shamt, FUNC_SLL);
            INS_SRL:   word = r_word(5'd0, rt, rd, shamt, FUNC_SRL);
            INS_SRA:   word = r_word(5'd0, rt, rd, shamt, FUNC_SRA);
            INS_SLLV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SLLV);
            INS_SRLV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SRLV);
            INS_SRAV:  word = r_word(rs, rt, rd, 5'd0, FUNC_SRAV);
            INS_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
            INS_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
            INS_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
            INS_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
            INS_ORI:   word = i_word(OP_ORI, rs, rt, imm);
            INS_XORI:  word = i_word(OP_XORI, rs, rt, imm);
            INS_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
            INS_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
            INS_LW:    word = i_word(OP_LW, rs, rt, imm);
            INS_SW:    word = i_word(OP_SW, rs, rt, imm);
            INS_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
            INS_BNE:   word = i_word(OP_BNE, rs, rt, imm);
            INS_J:     word = {OP_J, target};
            INS_JAL:   word = {OP_JAL, target};
            default:   illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ins_encoder.sv
// Instruction encoder: packs host-supplied fields into MIPS32 words and streams them into imem.
// ENC_DELAY_SLOT_PAD_EN: append a NOP after every J/JAL/BEQ/BNE/JR write.
module ins_encoder
    import ins_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fin,
    input  logic              in_valid,
    output logic              in_ready,
    input  ins_op_t           in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    enc_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic              pad_pending;
    logic [31:0]       word;
    logic              illegal;
    logic              full, xfer, pad_req;
    logic              do_wr, go_err;
    logic [31:0]       wr_word;

    ins_pack u_pack (
        .op(in_op), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
        .imm(in_imm), .target(in_target), .word(word), .illegal(illegal)
    );

    assign full     = (count == CAP);
    assign in_ready = (state == ST_LOAD) && !full && !pad_pending;
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == ST_LOAD) || (state == ST_DRAIN) || imem_we;

`ifdef ENC_DELAY_SLOT_PAD_EN
    assign pad_req = needs_pad(in_op);
`else
    assign pad_req = 1'b0;
`endif

    // Decide this cycle's write (instruction or NOP pad) and any error entry.
    always_comb begin
        do_wr   = 1'b0;
        go_err  = 1'b0;
        wr_word = word;
        if (!start) begin
            case (state)
                ST_LOAD: begin
                    if ((in_valid && full) || (xfer && illegal) || (pad_pending && full))
                        go_err = 1'b1;
                    else if (xfer)
                        do_wr = 1'b1;
                    else if (pad_pending) begin
                        do_wr   = 1'b1;
                        wr_word = '0;
                    end
                end
                ST_DRAIN: begin
                    if (pad_pending && full)
                        go_err = 1'b1;
                    else if (pad_pending) begin
                        do_wr   = 1'b1;
                        wr_word = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            count       <= '0;
            pad_pending <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            imem_we <= do_wr;
            if (do_wr) begin
                imem_wdata <= wr_word;
                imem_addr  <= ptr;
                ptr        <= ptr + 1'b1;
                count      <= count + 1'b1;
            end
            if (start) begin
                state       <= ST_LOAD;
                ptr         <= ADDR_W'(BASE_ADDR);
                count       <= '0;
                pad_pending <= 1'b0;
                done        <= 1'b0;
                err         <= 1'b0;
            end else if (go_err) begin
                state       <= ST_ERR;
                err         <= 1'b1;
                pad_pending <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (xfer)
                            pad_pending <= pad_req;
                        else if (pad_pending)
                            pad_pending <= 1'b0;
                        if (fin) begin
                            if (do_wr || (xfer && pad_req))
                                state <= ST_DRAIN;
                            else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pad_pending)
                            pad_pending <= 1'b0;
                        else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
